// File: rtl/pps_div_multi.sv
// Multi-channel PPS divider: N_CH channels share one PPS synchroniser, one us prescaler and one byte register bus.
// Define PPS_DIV_READBACK_EN to make CTRL/DIV/PHASE_US/WIDTH_US readable; otherwise only STATUS reads back.
module pps_div_multi #(
   parameter int         N_CH       = 4,
   parameter logic [7:0] BASE_ADDR  = 8'h20,
   parameter int         CLK_PER_US = 10
) (
   input  logic            i_clk_10,
   input  logic            i_rst,
   input  logic [7:0]      i_addr,
   input  logic [7:0]      i_data,
   input  logic            i_wr,
   input  logic            i_pps_raw,
   output logic [7:0]      o_data,
   output logic [N_CH-1:0] o_pps_divided
);

   localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

   typedef enum logic [1:0] {IDLE, WAIT_PPS, PHASE, HIGH} state_t;

   state_t          state     [N_CH];
   logic [N_CH-1:0] periodic;
   logic [N_CH-1:0] overrun;
   logic [7:0]      div_reg   [N_CH];
   logic [31:0]     phase_reg [N_CH];
   logic [7:0]      width_reg [N_CH];
   logic [7:0]      div_sh    [N_CH];
   logic [7:0]      width_sh  [N_CH];
   logic [7:0]      pps_cnt   [N_CH];
   logic [31:0]     phase_cnt [N_CH];
   logic [7:0]      width_cnt [N_CH];

   logic [2:0]      pps_sync;
   logic            pps_edge;
   logic            us_tick;
   logic [PW-1:0]   presc;
   logic [7:0]      rel;
   logic [3:0]      ch_sel;
   logic [2:0]      offs;
   logic            in_range;
   logic [N_CH-1:0] wr_sel;
   logic [N_CH-1:0] start_cmd;
   logic [N_CH-1:0] stop_cmd;
   logic [7:0]      eff_div   [N_CH];
   logic [7:0]      cnt_next  [N_CH];
   logic [7:0]      rd_val;

   assign pps_edge = pps_sync[1] & ~pps_sync[2];
   assign us_tick  = (presc == PW'(CLK_PER_US - 1));
   assign rel      = i_addr - BASE_ADDR;
   assign in_range = (i_addr >= BASE_ADDR) && ({1'b0, rel} < 9'(8 * N_CH));
   assign ch_sel   = rel[6:3];
   assign offs     = rel[2:0];

   // STOP beats START when both strobes arrive in one CTRL write
   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         wr_sel[k]    = i_wr && in_range && (ch_sel == 4'(k));
         start_cmd[k] = wr_sel[k] && (offs == 3'd0) && i_data[1] && !i_data[2];
         stop_cmd[k]  = wr_sel[k] && (offs == 3'd0) && i_data[2];
         eff_div[k]   = (div_reg[k] == 8'd0) ? 8'd1 : div_reg[k];
         cnt_next[k]  = ((pps_cnt[k] + 8'd1) == div_sh[k]) ? 8'd0 : pps_cnt[k] + 8'd1;
      end
   end

   always_comb begin
      rd_val = 8'h00;
      for (int k = 0; k < N_CH; k++) begin
         if (in_range && (ch_sel == 4'(k))) begin
            case (offs)
`ifdef PPS_DIV_READBACK_EN
               3'd0: rd_val = {7'd0, periodic[k]};
               3'd1: rd_val = div_reg[k];
               3'd2: rd_val = phase_reg[k][7:0];
               3'd3: rd_val = phase_reg[k][15:8];
               3'd4: rd_val = phase_reg[k][23:16];
               3'd5: rd_val = phase_reg[k][31:24];
               3'd6: rd_val = width_reg[k];
`endif
               3'd7: rd_val = {5'd0, overrun[k], o_pps_divided[k], state[k] != IDLE};
               default: rd_val = 8'h00;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk_10) begin
      if (i_rst) begin
         pps_sync      <= '0;
         presc         <= '0;
         o_data        <= 8'h00;
         o_pps_divided <= '0;
         periodic      <= '0;
         overrun       <= '0;
         for (int k = 0; k < N_CH; k++) begin
            state[k]     <= IDLE;
            div_reg[k]   <= 8'd0;
            phase_reg[k] <= 32'd0;
            width_reg[k] <= 8'd0;
            div_sh[k]    <= 8'd0;
            width_sh[k]  <= 8'd0;
            pps_cnt[k]   <= 8'd0;
            phase_cnt[k] <= 32'd0;
            width_cnt[k] <= 8'd0;
         end
      end else begin
         pps_sync <= {pps_sync[1:0], i_pps_raw};
         presc    <= (pps_edge || us_tick) ? '0 : presc + PW'(1);
         o_data   <= rd_val;
         for (int k = 0; k < N_CH; k++) begin
            if (wr_sel[k]) begin
               case (offs)
                  3'd0: periodic[k]            <= i_data[0];
                  3'd1: div_reg[k]             <= i_data;
                  3'd2: phase_reg[k][7:0]      <= i_data;
                  3'd3: phase_reg[k][15:8]     <= i_data;
                  3'd4: phase_reg[k][23:16]    <= i_data;
                  3'd5: phase_reg[k][31:24]    <= i_data;
                  3'd6: width_reg[k]           <= i_data;
                  default: ;
               endcase
            end
            // Shadow copies are taken only on a qualifying edge, so bus writes never disturb a pulse in flight
            if (stop_cmd[k]) begin
               state[k]         <= IDLE;
               o_pps_divided[k] <= 1'b0;
            end else begin
               case (state[k])
                  IDLE: begin
                     if (start_cmd[k]) begin
                        pps_cnt[k] <= 8'd0;
                        overrun[k] <= 1'b0;
                        state[k]   <= WAIT_PPS;
                     end
                  end
                  WAIT_PPS: begin
                     if (pps_edge) begin
                        if (pps_cnt[k] == 8'd0) begin
                           div_sh[k]   <= eff_div[k];
                           width_sh[k] <= width_reg[k];
                           pps_cnt[k]  <= (eff_div[k] == 8'd1) ? 8'd0 : 8'd1;
                           if (phase_reg[k] != 32'd0) begin
                              phase_cnt[k] <= phase_reg[k];
                              state[k]     <= PHASE;
                           end else if (width_reg[k] != 8'd0) begin
                              width_cnt[k]     <= width_reg[k];
                              o_pps_divided[k] <= 1'b1;
                              state[k]         <= HIGH;
                           end else begin
                              state[k] <= periodic[k] ? WAIT_PPS : IDLE;
                           end
                        end else begin
                           pps_cnt[k] <= cnt_next[k];
                        end
                     end
                  end
                  PHASE: begin
                     if (pps_edge) begin
                        pps_cnt[k] <= cnt_next[k];
                        if (pps_cnt[k] == 8'd0) overrun[k] <= 1'b1;
                     end
                     if (us_tick) begin
                        if (phase_cnt[k] == 32'd1) begin
                           if (width_sh[k] != 8'd0) begin
                              width_cnt[k]     <= width_sh[k];
                              o_pps_divided[k] <= 1'b1;
                              state[k]         <= HIGH;
                           end else begin
                              state[k] <= periodic[k] ? WAIT_PPS : IDLE;
                           end
                        end else begin
                           phase_cnt[k] <= phase_cnt[k] - 32'd1;
                        end
                     end
                  end
                  HIGH: begin
                     if (pps_edge) begin
                        pps_cnt[k] <= cnt_next[k];
                        if (pps_cnt[k] == 8'd0) overrun[k] <= 1'b1;
                     end
                     if (us_tick) begin
                        if (width_cnt[k] == 8'd1) begin
                           o_pps_divided[k] <= 1'b0;
                           state[k]         <= periodic[k] ? WAIT_PPS : IDLE;
                        end else begin
                           width_cnt[k] <= width_cnt[k] - 8'd1;
                        end
                     end
                  end
                  default: state[k] <= IDLE;
               endcase
            end
         end
      end
   end

endmodule
